// File: rtl/lcd_stream_capture.sv
// lcd_stream_capture: sink for the dual-pixel LCD stream. It counts and checksums every
// pair of a frame, tracks the raster position, captures a programmable window of pairs
// into a dual-port RAM and exposes status plus captured pixels on an AHB slave port.
module lcd_stream_capture #(
   parameter int W_ADDR      = 32,
   parameter int W_DATA      = 32,
   parameter int IMG_PIX_W   = 8,
   parameter int WIDTH       = 768,
   parameter int HEIGHT      = 512,
   parameter int FRAME_PAIRS = WIDTH * HEIGHT / 2,
   parameter int CAP_DEPTH   = 4096
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 sl_HSEL,
   input  logic                 sl_HREADY,
   input  logic [1:0]           sl_HTRANS,
   input  logic [2:0]           sl_HBURST,
   input  logic [2:0]           sl_HSIZE,
   input  logic                 sl_HWRITE,
   input  logic [W_ADDR-1:0]    sl_HADDR,
   input  logic [W_DATA-1:0]    sl_HWDATA,
   output logic                 out_sl_HREADY,
   output logic [1:0]           out_sl_HRESP,
   output logic [W_DATA-1:0]    out_sl_HRDATA,
   input  logic                 in_valid,
   input  logic [IMG_PIX_W-1:0] in_r0,
   input  logic [IMG_PIX_W-1:0] in_g0,
   input  logic [IMG_PIX_W-1:0] in_b0,
   input  logic [IMG_PIX_W-1:0] in_r1,
   input  logic [IMG_PIX_W-1:0] in_g1,
   input  logic [IMG_PIX_W-1:0] in_b1,
   output logic                 out_irq
);
   localparam int W_PC   = $clog2(FRAME_PAIRS + 1);
   localparam int W_CAP  = $clog2(CAP_DEPTH);
   localparam int W_PIX  = 3 * IMG_PIX_W;
   localparam int W_PAIR = 6 * IMG_PIX_W;
   localparam logic [W_PC:0]   CAP_EXT   = (W_PC + 1)'(CAP_DEPTH);
   localparam logic [W_PC-1:0] LAST_PAIR = W_PC'(FRAME_PAIRS - 1);
   localparam logic [11:0]     LAST_COL  = 12'(WIDTH - 2);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3} state_t;

   state_t            state_reg;
   logic [W_PC-1:0]   pair_cnt_reg;
   logic [W_PC-1:0]   skip_reg;
   logic [31:0]       checksum_reg;
   logic [11:0]       row_reg;
   logic [11:0]       col_reg;
   logic [15:0]       frame_cnt_reg;
   logic              done_reg;
   logic              late_reg;
   logic              irq_en_reg;

   // AHB pipeline state
   logic              wr_pend_reg;
   logic [3:0]        wr_idx_reg;
   logic              img_wait_reg;
   logic              img_out_reg;
   logic [W_CAP-1:0]  img_pair_reg;
   logic              img_sel_reg;
   logic [31:0]       hrdata_reg;
   logic [31:0]       reg_rdata;

   // capture RAM
   logic [W_PAIR-1:0] cap_ram [CAP_DEPTH];
   logic [W_PAIR-1:0] ram_q;
   logic              ram_we;
   logic [W_CAP-1:0]  ram_waddr;
   logic [W_PAIR-1:0] ram_wdata;

   logic              accept;
   logic              ctrl_wr;
   logic              skip_wr;
   logic              stat_wr;
   logic              arm_p;
   logic              clear_p;
   logic              take;
   logic [31:0]       pix_sum;
   logic [W_PC:0]     pair_ext;
   logic [W_PC:0]     skip_ext;
   logic [W_PC:0]     rel_addr;
   logic [W_PIX-1:0]  img_pix;
   logic              unused_bits;

   assign accept  = sl_HSEL & sl_HREADY & sl_HTRANS[1];
   assign ctrl_wr = wr_pend_reg & (wr_idx_reg == 4'd0);
   assign skip_wr = wr_pend_reg & (wr_idx_reg == 4'd1);
   assign stat_wr = wr_pend_reg & (wr_idx_reg == 4'd2);
   assign clear_p = ctrl_wr & sl_HWDATA[1];
   assign arm_p   = ctrl_wr & sl_HWDATA[0];

   // A pair counts only while waiting for the first pair or mid-frame.
   assign take    = in_valid & ((state_reg == S_ARMED) | (state_reg == S_CAPTURE));
   assign pix_sum = 32'(in_r0) + 32'(in_g0) + 32'(in_b0) + 32'(in_r1) + 32'(in_g1) + 32'(in_b1);

   // Window test is done one bit wider than the counters so SKIP+CAP_DEPTH never wraps.
   assign pair_ext  = {1'b0, pair_cnt_reg};
   assign skip_ext  = {1'b0, skip_reg};
   assign rel_addr  = pair_ext - skip_ext;
   assign ram_we    = take & (pair_ext >= skip_ext) & (pair_ext < (skip_ext + CAP_EXT));
   assign ram_waddr = rel_addr[W_CAP-1:0];
   assign ram_wdata = {in_r1, in_g1, in_b1, in_r0, in_g0, in_b0};

   assign img_pix       = img_sel_reg ? ram_q[W_PAIR-1:W_PIX] : ram_q[W_PIX-1:0];
   assign out_sl_HRDATA = img_out_reg ? W_DATA'(img_pix) : W_DATA'(hrdata_reg);
   assign out_sl_HREADY = ~img_wait_reg;
   assign out_sl_HRESP  = 2'b00;
   assign out_irq       = done_reg & irq_en_reg;

   assign unused_bits = ^{sl_HBURST, sl_HSIZE, sl_HTRANS[0], sl_HADDR, sl_HWDATA, rel_addr};

   // Register read mux, sampled at address-phase acceptance.
   always_comb begin
      reg_rdata = '0;
      case (sl_HADDR[5:2])
         4'd0: reg_rdata[2] = irq_en_reg;
         4'd1: reg_rdata[W_PC-1:0] = skip_reg;
         4'd2: reg_rdata[3:0] = {late_reg, done_reg, state_reg};
         4'd3: reg_rdata[W_PC-1:0] = pair_cnt_reg;
         4'd4: begin
            reg_rdata[27:16] = row_reg;
            reg_rdata[11:0]  = col_reg;
         end
         4'd5: reg_rdata = checksum_reg;
         4'd6: reg_rdata[15:0] = frame_cnt_reg;
         default: reg_rdata = '0;
      endcase
   end

   // AHB front end: latch the address phase, insert one wait state for image reads.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_pend_reg  <= 1'b0;
         wr_idx_reg   <= '0;
         img_wait_reg <= 1'b0;
         img_out_reg  <= 1'b0;
         img_pair_reg <= '0;
         img_sel_reg  <= 1'b0;
         hrdata_reg   <= '0;
      end else begin
         wr_pend_reg  <= accept & sl_HWRITE & ~sl_HADDR[15];
         img_wait_reg <= accept & ~sl_HWRITE & sl_HADDR[15];
         img_out_reg  <= img_wait_reg;
         if (accept) begin
            wr_idx_reg   <= sl_HADDR[5:2];
            img_pair_reg <= sl_HADDR[W_CAP+2:3];
            img_sel_reg  <= sl_HADDR[2];
         end
         if (accept & ~sl_HWRITE & ~sl_HADDR[15])
            hrdata_reg <= reg_rdata;
      end
   end

   // Capture RAM: write from the stream, registered read during the image wait state.
   always_ff @(posedge HCLK) begin
      if (ram_we)
         cap_ram[ram_waddr] <= ram_wdata;
      if (img_wait_reg)
         ram_q <= cap_ram[img_pair_reg];
   end

   // Capture FSM with counters; clear beats arm, arm beats the stream.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg     <= S_IDLE;
         pair_cnt_reg  <= '0;
         skip_reg      <= '0;
         checksum_reg  <= '0;
         row_reg       <= '0;
         col_reg       <= '0;
         frame_cnt_reg <= '0;
         done_reg      <= 1'b0;
         late_reg      <= 1'b0;
         irq_en_reg    <= 1'b0;
      end else begin
         if (ctrl_wr)
            irq_en_reg <= sl_HWDATA[2];
         if (skip_wr)
            skip_reg <= sl_HWDATA[W_PC-1:0];
         if (clear_p || (arm_p && (state_reg == S_IDLE || state_reg == S_DONE))) begin
            state_reg    <= clear_p ? S_IDLE : S_ARMED;
            pair_cnt_reg <= '0;
            checksum_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            done_reg     <= 1'b0;
            late_reg     <= 1'b0;
         end else begin
            if (take) begin
               pair_cnt_reg <= pair_cnt_reg + 1'b1;
               checksum_reg <= checksum_reg + pix_sum;
               if (col_reg == LAST_COL) begin
                  col_reg <= '0;
                  row_reg <= row_reg + 1'b1;
               end else begin
                  col_reg <= col_reg + 12'd2;
               end
               if (pair_cnt_reg == LAST_PAIR) begin
                  state_reg     <= S_DONE;
                  done_reg      <= 1'b1;
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
               end else begin
                  state_reg <= S_CAPTURE;
               end
            end
            if (in_valid && state_reg == S_DONE)
               late_reg <= 1'b1;
            else if (stat_wr && sl_HWDATA[3])
               late_reg <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lcd_stream_capture.sv
// tb_lcd_stream_capture: directed bench for a reduced 16x8 frame with a 16-pair capture RAM.
// Reads push their expected data and wait-state count into a scoreboard; a monitor pops
// and compares whenever a read data phase completes.
`timescale 1ns/1ps
module tb_lcd_stream_capture;
   localparam int WIDTH  = 16;
   localparam int HEIGHT = 8;
   localparam int FP     = 64;
   localparam int CAPD   = 16;

   localparam logic [31:0] A_CTRL = 32'h00;
   localparam logic [31:0] A_SKIP = 32'h04;
   localparam logic [31:0] A_STAT = 32'h08;
   localparam logic [31:0] A_PCNT = 32'h0C;
   localparam logic [31:0] A_POS  = 32'h10;
   localparam logic [31:0] A_CSUM = 32'h14;
   localparam logic [31:0] A_FCNT = 32'h18;
   localparam logic [31:0] A_IMG  = 32'h8000;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        sl_HSEL = 1'b0;
   logic [1:0]  sl_HTRANS = 2'b00;
   logic [2:0]  sl_HBURST = 3'b000;
   logic [2:0]  sl_HSIZE = 3'b010;
   logic        sl_HWRITE = 1'b0;
   logic [31:0] sl_HADDR = '0;
   logic [31:0] sl_HWDATA = '0;
   logic        out_sl_HREADY;
   logic [1:0]  out_sl_HRESP;
   logic [31:0] out_sl_HRDATA;
   logic        in_valid = 1'b0;
   logic [7:0]  in_r0 = '0, in_g0 = '0, in_b0 = '0, in_r1 = '0, in_g1 = '0, in_b1 = '0;
   logic        out_irq;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q [$];
   int          expw_q [$];
   string       name_q [$];

   always #5 HCLK = ~HCLK;

   lcd_stream_capture #(
      .W_ADDR(32), .W_DATA(32), .IMG_PIX_W(8), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
      .FRAME_PAIRS(FP), .CAP_DEPTH(CAPD)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .sl_HSEL(sl_HSEL), .sl_HREADY(out_sl_HREADY), .sl_HTRANS(sl_HTRANS),
      .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE), .sl_HWRITE(sl_HWRITE),
      .sl_HADDR(sl_HADDR), .sl_HWDATA(sl_HWDATA),
      .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA),
      .in_valid(in_valid), .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
      .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1), .out_irq(out_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: tracks read data phases and checks each completed one against the scoreboard.
   logic        dph = 1'b0;
   int          wcnt = 0;
   string       m_name;
   logic [31:0] m_exp;
   int          m_w;
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         dph = 1'b0;
      end else begin
         if (dph) begin
            if (out_sl_HREADY) begin
               dph = 1'b0;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_read: got 0x%08h, expected no read", out_sl_HRDATA);
               end else begin
                  m_name = name_q.pop_front();
                  m_exp  = exp_q.pop_front();
                  m_w    = expw_q.pop_front();
                  $display("[TB] read %s data=0x%08h waits=%0d", m_name, out_sl_HRDATA, wcnt);
                  check(m_name, out_sl_HRDATA, m_exp);
                  check({m_name, "_waits"}, wcnt, m_w);
               end
            end else begin
               wcnt++;
            end
         end
         if (!dph && sl_HSEL && sl_HTRANS[1] && out_sl_HREADY && !sl_HWRITE) begin
            dph  = 1'b1;
            wcnt = 0;
         end
      end
   end

   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = a;
      @(posedge HCLK); #1;
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = d;
      @(posedge HCLK); #1;
      $display("[TB] write addr=0x%08h data=0x%08h", a, d);
   endtask

   task automatic ahb_read(input logic [31:0] a, input logic [31:0] e, input int w, input string n);
      int k;
      k = 0;
      exp_q.push_back(e);
      expw_q.push_back(w);
      name_q.push_back(n);
      @(posedge HCLK); #1;
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = a;
      @(posedge HCLK); #1;
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
      while (!out_sl_HREADY && k < 8) begin
         @(posedge HCLK); #1;
         k++;
      end
      if (k == 8) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got HREADY low for %0d cycles, expected at most 1", n, k);
      end
   endtask

   // mode 0: constant 1..6 ; mode 1: ramp keyed on the pair index
   task automatic drive_pair(input int p, input int mode);
      logic [7:0] pb;
      pb = p[7:0];
      if (mode == 0) begin
         in_r0 = 8'd1; in_g0 = 8'd2; in_b0 = 8'd3; in_r1 = 8'd4; in_g1 = 8'd5; in_b1 = 8'd6;
      end else begin
         in_r0 = pb; in_g0 = 8'h00; in_b0 = 8'h00; in_r1 = pb + 8'h40; in_g1 = 8'h11; in_b1 = pb;
      end
   endtask

   // Streams pairs with a 3-cycle blanking gap before every new line.
   task automatic send_pairs(input int first, input int n, input int mode);
      int p;
      for (int i = 0; i < n; i++) begin
         p = first + i;
         @(posedge HCLK); #1;
         if (i > 0 && (p % (WIDTH / 2)) == 0) begin
            in_valid = 1'b0;
            repeat (3) @(posedge HCLK);
            #1;
         end
         in_valid = 1'b1;
         drive_pair(p, mode);
      end
      @(posedge HCLK); #1;
      in_valid = 1'b0;
      $display("[TB] stream pairs %0d..%0d mode %0d", first, first + n - 1, mode);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      // T1 reset values
      repeat (3) @(negedge HCLK);
      check("rst_irq", {31'b0, out_irq}, 32'd0);
      check("rst_hready", {31'b0, out_sl_HREADY}, 32'd1);
      check("rst_hrdata", out_sl_HRDATA, 32'd0);
      HRESETn = 1'b1;
      ahb_read(A_CTRL, 32'h0, 0, "t1_ctrl");
      ahb_read(A_SKIP, 32'h0, 0, "t1_skip");
      ahb_read(A_STAT, 32'h0, 0, "t1_status");
      ahb_read(A_PCNT, 32'h0, 0, "t1_paircnt");
      ahb_read(A_POS,  32'h0, 0, "t1_pos");
      ahb_read(A_CSUM, 32'h0, 0, "t1_checksum");
      ahb_read(A_FCNT, 32'h0, 0, "t1_framecnt");

      // T2 full frame, constant pattern, SKIP=0
      ahb_write(A_SKIP, 32'd0);
      ahb_write(A_CTRL, 32'h1);
      ahb_read(A_STAT, 32'h1, 0, "t2_armed");
      send_pairs(0, 10, 0);
      ahb_read(A_PCNT, 32'd10, 0, "t2_paircnt_mid");
      ahb_read(A_POS, 32'h0001_0004, 0, "t2_pos_mid");
      ahb_read(A_STAT, 32'h2, 0, "t2_capture");
      send_pairs(10, FP - 10, 0);
      ahb_read(A_STAT, 32'h7, 0, "t2_done");
      ahb_read(A_PCNT, 32'd64, 0, "t2_paircnt");
      ahb_read(A_CSUM, 32'h0000_0540, 0, "t2_checksum");
      ahb_read(A_POS, 32'h0008_0000, 0, "t2_pos_end");
      ahb_read(A_FCNT, 32'd1, 0, "t2_framecnt");
      ahb_read(A_IMG + 32'd0, 32'h0001_0203, 1, "t2_img_w0");
      ahb_read(A_IMG + 32'd4, 32'h0004_0506, 1, "t2_img_w1");
      check("t2_irq_disabled", {31'b0, out_irq}, 32'd0);

      // T3 capture window starting at line 1, ramp pattern
      ahb_write(A_SKIP, 32'd8);
      ahb_write(A_CTRL, 32'h1);
      send_pairs(0, FP, 1);
      ahb_read(A_STAT, 32'h7, 0, "t3_done");
      ahb_read(A_CSUM, 32'h0000_2BE0, 0, "t3_checksum");
      ahb_read(A_FCNT, 32'd2, 0, "t3_framecnt");
      ahb_read(A_IMG + 32'd0,   32'h0008_0000, 1, "t3_img_w0");
      ahb_read(A_IMG + 32'd4,   32'h0048_1108, 1, "t3_img_w1");
      ahb_read(A_IMG + 32'd120, 32'h0017_0000, 1, "t3_img_w30");
      ahb_read(A_IMG + 32'd124, 32'h0057_1117, 1, "t3_img_w31");

      // T4 interrupt, late flag and its write-1-to-clear
      ahb_write(A_SKIP, 32'd0);
      ahb_write(A_CTRL, 32'h5);
      ahb_read(A_CTRL, 32'h4, 0, "t4_ctrl");
      send_pairs(0, FP - 1, 0);
      @(posedge HCLK); #1;
      in_valid = 1'b1;
      drive_pair(FP - 1, 0);
      @(negedge HCLK);
      check("t4_irq_before_last", {31'b0, out_irq}, 32'd0);
      @(posedge HCLK); #1;
      in_valid = 1'b0;
      @(negedge HCLK);
      check("t4_irq_after_last", {31'b0, out_irq}, 32'd1);
      @(posedge HCLK); #1;
      in_valid = 1'b1;
      @(posedge HCLK); #1;
      in_valid = 1'b0;
      ahb_read(A_STAT, 32'hF, 0, "t4_late");
      ahb_read(A_PCNT, 32'd64, 0, "t4_paircnt_held");
      ahb_write(A_STAT, 32'h8);
      ahb_read(A_STAT, 32'h7, 0, "t4_late_cleared");
      ahb_read(A_FCNT, 32'd3, 0, "t4_framecnt");
      ahb_write(A_CTRL, 32'h0);
      check("t4_irq_masked", {31'b0, out_irq}, 32'd0);

      // T5 clear mid-capture
      ahb_write(A_CTRL, 32'h1);
      send_pairs(0, 20, 0);
      ahb_read(A_STAT, 32'h2, 0, "t5_capture");
      ahb_write(A_CTRL, 32'h2);
      ahb_read(A_STAT, 32'h0, 0, "t5_idle");
      ahb_read(A_PCNT, 32'h0, 0, "t5_paircnt");
      send_pairs(0, 5, 0);
      ahb_read(A_PCNT, 32'h0, 0, "t5_ignored");
      ahb_read(A_CSUM, 32'h0, 0, "t5_checksum");
      ahb_write(A_CTRL, 32'h3);
      ahb_read(A_STAT, 32'h0, 0, "t5_clear_wins");

      // T6 asynchronous reset mid-capture
      ahb_write(A_SKIP, 32'd5);
      ahb_write(A_CTRL, 32'h5);
      send_pairs(0, 10, 0);
      ahb_read(A_STAT, 32'h2, 0, "t6_capture");
      @(posedge HCLK); #3;
      HRESETn = 1'b0;
      #1;
      check("t6_hrdata", out_sl_HRDATA, 32'd0);
      check("t6_hready", {31'b0, out_sl_HREADY}, 32'd1);
      check("t6_irq", {31'b0, out_irq}, 32'd0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      ahb_read(A_CTRL, 32'h0, 0, "t6_ctrl");
      ahb_read(A_SKIP, 32'h0, 0, "t6_skip");
      ahb_read(A_STAT, 32'h0, 0, "t6_status");
      ahb_read(A_PCNT, 32'h0, 0, "t6_paircnt");
      ahb_read(A_FCNT, 32'h0, 0, "t6_framecnt");

      for (int k = 0; k < 20 && exp_q.size() != 0; k++)
         @(posedge HCLK);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
